// File: rtl/xor_pkg.sv
// Shared types and helpers for the XOR frame checksum block.
package xor_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } xor_state_t;

   function automatic int sat_inc(input int cnt, input int max);
      return (cnt >= max) ? max : cnt + 1;
   endfunction

endpackage

// File: rtl/xor_word_reduce.sv
// Word-wide XOR of two operands plus the odd parity of the result.
module xor_word_reduce #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] y_o,
   output logic             parity_o
);

   assign y_o      = a_i ^ b_i;
   assign parity_o = ^y_o;

endmodule

// File: rtl/xor_frame_checksum.sv
// Streams WIDTH-bit words over valid/ready, XOR-accumulating a frame and
// presenting checksum, parity, saturating word count and overflow on the last beat.
//
// state | meaning
// ACCUM | collecting beats, in_ready high
// HOLD  | frame result presented, waiting for out_ready
module xor_frame_checksum
   import xor_pkg::*;
#(
   parameter  int WIDTH     = 8,
   parameter  int MAX_WORDS = 16,
   localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_checksum,
   output logic             out_parity,
   output logic [CNT_W-1:0] out_count,
   output logic             out_overflow
);

   xor_state_t       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_checksum_q, out_checksum_d;
   logic             out_parity_q, out_parity_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic             out_overflow_q, out_overflow_d;

   logic             accept;
   logic [WIDTH-1:0] data_gated;
   logic [WIDTH-1:0] acc_next;
   logic             acc_next_parity;
   logic [CNT_W-1:0] cnt_inc;
   logic             cnt_at_max;

   assign in_ready = (state_q == ACCUM);
   assign accept   = in_valid & in_ready;

   // Idle-cycle data is forced to zero so junk on in_data never reaches acc.
   assign data_gated = accept ? in_data : '0;

   xor_word_reduce #(
      .WIDTH (WIDTH)
   ) u_reduce (
      .a_i      (acc_q),
      .b_i      (data_gated),
      .y_o      (acc_next),
      .parity_o (acc_next_parity)
   );

   assign cnt_inc    = CNT_W'(sat_inc(int'(cnt_q), MAX_WORDS));
   assign cnt_at_max = (cnt_q == CNT_W'(MAX_WORDS));

   always_comb begin
      state_d        = state_q;
      acc_d          = acc_q;
      cnt_d          = cnt_q;
      ovf_d          = ovf_q;
      out_valid_d    = out_valid_q;
      out_checksum_d = out_checksum_q;
      out_parity_d   = out_parity_q;
      out_count_d    = out_count_q;
      out_overflow_d = out_overflow_q;

      unique case (state_q)
         ACCUM: begin
            if (accept) begin
               if (in_last) begin
                  out_checksum_d = acc_next;
                  out_parity_d   = acc_next_parity;
                  out_count_d    = cnt_inc;
                  out_overflow_d = ovf_q | cnt_at_max;
                  out_valid_d    = 1'b1;
                  acc_d          = '0;
                  cnt_d          = '0;
                  ovf_d          = 1'b0;
                  state_d        = HOLD;
               end else begin
                  acc_d = acc_next;
                  cnt_d = cnt_inc;
                  ovf_d = ovf_q | cnt_at_max;
               end
            end
         end
         HOLD: begin
            // Result registers keep their values after the handshake.
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ACCUM;
         acc_q          <= '0;
         cnt_q          <= '0;
         ovf_q          <= 1'b0;
         out_valid_q    <= 1'b0;
         out_checksum_q <= '0;
         out_parity_q   <= 1'b0;
         out_count_q    <= '0;
         out_overflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         acc_q          <= acc_d;
         cnt_q          <= cnt_d;
         ovf_q          <= ovf_d;
         out_valid_q    <= out_valid_d;
         out_checksum_q <= out_checksum_d;
         out_parity_q   <= out_parity_d;
         out_count_q    <= out_count_d;
         out_overflow_q <= out_overflow_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_checksum = out_checksum_q;
   assign out_parity   = out_parity_q;
   assign out_count    = out_count_q;
   assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_xor_frame_checksum.sv
// Scoreboard bench: directed frames on an 8-bit/4-word instance and an exhaustive
// two-word sweep on a 1-bit instance compared against the Xor2 truth table.
module tb_xor_frame_checksum;

   typedef struct {
      logic [7:0] cs;
      logic       par;
      logic [2:0] cnt;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, in_last;
   logic [7:0] in_data;
   logic       out_valid, out_ready, out_parity, out_overflow;
   logic [7:0] out_checksum;
   logic [2:0] out_count;

   logic       in_valid1, in_ready1, in_last1, in_data1;
   logic       out_valid1, out_ready1, out_parity1, out_overflow1, out_checksum1;
   logic [2:0] out_count1;

   int n_tests = 0;
   int n_fail  = 0;
   exp_t sb_q[$];
   exp_t sb1_q[$];
   logic xor2_tt [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

   always #5 clk = ~clk;

   xor_frame_checksum #(.WIDTH(8), .MAX_WORDS(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_checksum(out_checksum),
      .out_parity(out_parity), .out_count(out_count), .out_overflow(out_overflow)
   );

   xor_frame_checksum #(.WIDTH(1), .MAX_WORDS(4)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_last(in_last1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_checksum(out_checksum1),
      .out_parity(out_parity1), .out_count(out_count1), .out_overflow(out_overflow1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the beat was accepted.
   task automatic send(input logic [7:0] d, input logic l, input exp_t e);
      int n = 0;
      in_valid = 1'b1; in_data = d; in_last = l;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("send_timeout", 32'(n), 32'(0));
      if (l) sb_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0; in_data = 8'hE7; in_last = 1'b1;
   endtask

   task automatic send1(input logic d, input logic l);
      int n = 0;
      in_valid1 = 1'b1; in_data1 = d; in_last1 = l;
      while (!in_ready1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("send1_timeout", 32'(n), 32'(0));
      @(negedge clk);
      in_valid1 = 1'b0; in_data1 = 1'b1; in_last1 = 1'b1;
   endtask

   // out_ready only changes just after a posedge, so negedge sampling sees the handshake.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) chk("unexpected_output", 32'(1), 32'(0));
         else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("checksum", 32'(out_checksum), 32'(e.cs));
            chk("parity",   32'(out_parity),   32'(e.par));
            chk("count",    32'(out_count),    32'(e.cnt));
            chk("overflow", 32'(out_overflow), 32'(e.ovf));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid1 && out_ready1) begin
         if (sb1_q.size() == 0) chk("unexpected_output1", 32'(1), 32'(0));
         else begin
            exp_t e;
            e = sb1_q.pop_front();
            chk("xor2_checksum", 32'(out_checksum1), 32'(e.cs[0]));
            chk("xor2_parity",   32'(out_parity1),   32'(e.par));
            chk("xor2_count",    32'(out_count1),    32'(e.cnt));
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1;
      in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
      in_valid1 = 1'b0; in_data1 = 1'b0; in_last1 = 1'b0; out_ready1 = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_in_ready",  32'(in_ready),  32'(1));
      chk("rst_checksum",  32'(out_checksum), 32'(0));
      chk("rst_parity",    32'(out_parity), 32'(0));
      chk("rst_count",     32'(out_count), 32'(0));
      chk("rst_overflow",  32'(out_overflow), 32'(0));

      // 1: reset mid-frame discards the partial frame
      send(8'h12, 1'b0, '{8'h00, 1'b0, 3'd0, 1'b0});
      send(8'h34, 1'b0, '{8'h00, 1'b0, 3'd0, 1'b0});
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("t1_out_valid", 32'(out_valid), 32'(0));
      chk("t1_in_ready",  32'(in_ready),  32'(1));
      send(8'hAA, 1'b1, '{8'hAA, 1'b0, 3'd1, 1'b0});

      // 2: three-word frame, immediate consume
      send(8'h0F, 1'b0, '{8'h00, 1'b0, 3'd0, 1'b0});
      send(8'hF0, 1'b0, '{8'h00, 1'b0, 3'd0, 1'b0});
      send(8'h3C, 1'b1, '{8'hC3, 1'b0, 3'd3, 1'b0});
      chk("t2_out_valid", 32'(out_valid), 32'(1));
      chk("t2_in_ready",  32'(in_ready),  32'(0));
      @(negedge clk);

      // 3: backpressure holds the result stable
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      send(8'h01, 1'b0, '{8'h00, 1'b0, 3'd0, 1'b0});
      send(8'h02, 1'b1, '{8'h03, 1'b0, 3'd2, 1'b0});
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_valid",    32'(out_valid),    32'(1));
         chk("t3_hold_checksum", 32'(out_checksum), 32'(8'h03));
         chk("t3_hold_parity",   32'(out_parity),   32'(0));
         chk("t3_hold_in_ready", 32'(in_ready),     32'(0));
         @(negedge clk);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t3_release_valid",    32'(out_valid), 32'(0));
      chk("t3_release_in_ready", 32'(in_ready),  32'(1));

      // 4: overflow past MAX_WORDS, then a clean frame
      for (int i = 1; i <= 6; i++)
         send(8'(i), (i == 6), '{8'h07, 1'b1, 3'd4, 1'b1});
      send(8'h80, 1'b1, '{8'h80, 1'b1, 3'd1, 1'b0});

      // 5: gaps with junk on the data lines
      send(8'h55, 1'b0, '{8'h00, 1'b0, 3'd0, 1'b0});
      in_data = 8'hDE; in_last = 1'b1;
      @(negedge clk);
      in_data = 8'h3B; in_last = 1'b0;
      @(negedge clk);
      send(8'hAA, 1'b1, '{8'hFF, 1'b0, 3'd2, 1'b0});

      // 6: Xor2 equivalence on the 1-bit instance
      for (int k = 0; k < 4; k++) begin
         logic [1:0] xy;
         exp_t e;
         xy = 2'(k);
         e.cs = {7'b0, xor2_tt[k]}; e.par = xor2_tt[k]; e.cnt = 3'd2; e.ovf = 1'b0;
         sb1_q.push_back(e);
         send1(xy[1], 1'b0);
         send1(xy[0], 1'b1);
      end

      n = 0;
      while ((sb_q.size() != 0 || sb1_q.size() != 0) && n < 100) begin
         @(negedge clk); n++;
      end
      chk("sb_drained",  32'(sb_q.size()),  32'(0));
      chk("sb1_drained", 32'(sb1_q.size()), 32'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
